// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state encodings, geometry and key code formula for the keypad scanner
package keypad_pkg;

  localparam int COLS = 4;
  localparam int ROWS = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  // key_code = row*4 + col
  function automatic logic [3:0] key_code_f(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - parameterised width two-flop synchronizer with synchronous active-low reset
module sync2 #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad column scanner with press and release debounce
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV     = 16'd1000,
  parameter logic [19:0] DEBOUNCE_CYC = 20'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 16'd1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = (DEBOUNCE_CYC > 20'd1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 16'd1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 20'd1);

  state_t           state, state_n;
  logic [DIV_W-1:0] div_cnt, div_n;
  logic [DEB_W-1:0] deb_cnt, deb_n;
  logic [1:0]       col_idx, col_n;
  logic [1:0]       row_sel, row_n;
  logic [3:0]       code_n;
  logic             valid_n;
  logic             held_n;
  logic [3:0]       rs;

  sync2 #(
    .WIDTH    (4),
    .RESET_VAL(4'hF)
  ) u_row_sync (
    .clk  (clk),
    .reset(reset),
    .d    (row_in),
    .q    (rs)
  );

  // Row 0 has priority when several rows of the driven column are low
  function automatic logic [1:0] first_low(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SCAN;
      div_cnt   <= '0;
      deb_cnt   <= '0;
      col_idx   <= 2'd0;
      row_sel   <= 2'd0;
      col_out   <= 4'b1110;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      div_cnt   <= div_n;
      deb_cnt   <= deb_n;
      col_idx   <= col_n;
      row_sel   <= row_n;
      col_out   <= ~(4'b0001 << col_n);
      key_code  <= code_n;
      key_valid <= valid_n;
      key_held  <= held_n;
    end
  end

  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    deb_n   = deb_cnt;
    col_n   = col_idx;
    row_n   = row_sel;
    code_n  = key_code;
    valid_n = 1'b0;
    held_n  = key_held;
    case (state)
      SCAN: begin
        if (div_cnt == DIV_LAST) begin
          div_n = '0;
          if (rs != 4'hF) begin
            row_n   = first_low(rs);
            deb_n   = '0;
            state_n = DEBOUNCE;
          end else begin
            col_n = col_idx + 2'd1;
          end
        end else begin
          div_n = div_cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (rs[row_sel]) begin
          div_n   = '0;
          deb_n   = '0;
          state_n = SCAN;
        end else if (deb_cnt == DEB_LAST) begin
          code_n  = key_code_f(row_sel, col_idx);
          valid_n = 1'b1;
          held_n  = 1'b1;
          deb_n   = '0;
          state_n = HELD;
        end else begin
          deb_n = deb_cnt + 1'b1;
        end
      end
      HELD: begin
        // Column stays frozen here; a low sample is release bounce and restarts the count
        if (!rs[row_sel]) begin
          deb_n = '0;
        end else if (deb_cnt == DEB_LAST) begin
          held_n  = 1'b0;
          col_n   = col_idx + 2'd1;
          div_n   = '0;
          deb_n   = '0;
          state_n = SCAN;
        end else begin
          deb_n = deb_cnt + 1'b1;
        end
      end
      default: state_n = SCAN;
    endcase
  end

endmodule
